fp_sign_inject_pipe: RTL
========================

# fp_sign_inject_pipe

Parametrised, elastic successor to the single-precision sign-injection unit in the FPU execute stage. Performs FSGNJ/FSGNJN/FSGNJX for single precision and, when FLEN=64, double precision, with RISC-V NaN-boxing on single-precision operands and results. It runs as a STAGES-deep valid/ready pipeline with an opaque tag carried alongside each result. Full throughput of one operation per cycle; downstream backpressure is honoured.

## Interface
- FLEN, 64, FP register width; legal values are 32 and 64 only.
- STAGES, 2, pipeline depth in cycles; must be at least 1.
- TAG_W, 5, width of the sideband tag (rd index) carried with each operation.

- i_clk  in  1  clock; all state on rising edge.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_valid  in  1  input operation offered.
- o_ready  out  1  block can accept this cycle.
- i_operand_a  in  FLEN  fs1.
- i_operand_b  in  FLEN  fs2.
- i_operation  in  riscv_pkg::instr_op_e  FSGNJ_S, FSGNJN_S, FSGNJX_S, FSGNJ_D, FSGNJN_D or FSGNJX_D.
- i_tag  in  TAG_W  sideband tag, returned unchanged.
- o_valid  out  1  result available.
- i_ready  in  1  downstream accepts the result.
- o_result  out  FLEN  result.
- o_tag  out  TAG_W  tag of the result.
- o_busy  out  1  at least one stage holds a valid operation.

## Operation
- **Accept:** an operation is accepted when i_valid && o_ready && the op is supported.
  - Supported ops: the three _S ops; the three _D ops only when FLEN=64.
  - An unsupported op is never accepted, produces no output and does not stall.
- **Sign select (sa = fs1 sign, sb = fs2 sign):**
  - FSGNJ → sb
  - FSGNJN → ~sb
  - FSGNJX → sa^sb
- **Magnitude:** always taken from fs1.
- **Double precision:** sign is bit 63; result = {sign, a[62:0]}.
- **Single precision, FLEN=32:** result = {sign, a[30:0]}.
- **Single precision, FLEN=64:**
  - Operands are unboxed per Configuration.
  - Result is NaN-boxed: {32'hFFFF_FFFF, sign, a'[30:0]}.
- **Pipeline:** result is computed combinationally at entry, then passes through STAGES registered stages.
  - Each stage holds {valid, result, tag}.
  - Stage k loads from stage k-1 when stage k is empty or stage k advances (bubble-collapsing).
  - The last stage advances when i_ready is high.
- **Ready:** o_ready = !stage0_valid || stage0 advances this cycle. It is combinational from i_ready through the valid chain.
- **Outputs:** o_valid, o_result and o_tag come directly from the last stage registers. They hold stable while o_valid && !i_ready.
- **Ordering:** results leave in acceptance order. No reordering, no drops.
- **Elaboration checks:** an illegal FLEN or STAGES < 1 raises $error at elaboration.

## Timing
- **Reset (i_rst_n low at an edge):** all valid bits, result and tag registers are cleared to 0.
  - o_valid=0, o_result=0, o_tag=0, o_busy=0.
  - o_ready=1 in the first cycle after reset.
- **Latency:** an operation accepted at edge N presents o_valid=1 after edge N+STAGES-1 when unstalled. STAGES=1 gives a result in the cycle after acceptance.
- **Throughput:** one operation per cycle while i_ready=1.
- **Full pipeline with i_ready=0:** all STAGES stages valid, o_ready=0, contents frozen.
- **Full pipeline with i_ready=1:** the last stage drains and a new op is accepted in the same cycle.
- **Reset mid-operation:** all in-flight operations are discarded; no output is produced for them.
- **Bubbles:** an empty stage is filled without waiting for i_ready.

## Configuration
- Macro: FP_SGNJ_NANBOX_CHECK_EN (only meaningful when FLEN=64).
- **Defined:** a single-precision operand whose bits [63:32] are not all ones is replaced by canonical NaN 32'h7FC0_0000 before sign and magnitude extraction. This applies to fs1 and fs2 independently.
- **Undefined:** bits [63:32] of single-precision operands are ignored; the low 32 bits are used as-is.
- In both builds, single-precision results are always NaN-boxed.

## Structure
- **riscv_pkg:**
  - Add FSGNJ_D, FSGNJN_D and FSGNJX_D to instr_op_e.
  - Add constant FP_CANON_NAN_S = 32'h7FC0_0000.
- **Sub-module fp_pipe_stage:** one elastic register stage.
  - Parameter W.
  - Ports: i_valid/o_ready in, o_valid/i_ready out, i_data/o_data.
  - Synchronous active-low reset.
  - Instantiated STAGES times via generate, with W = FLEN+TAG_W.

## Test plan
- **Basic single, no stall:** FLEN=64, STAGES=2, FSGNJN_S, a=b=64'hFFFFFFFF_3F800000, tag 3. Require o_result=64'hFFFFFFFF_BF800000 and o_tag=3, with o_valid 2 cycles after acceptance.
- **Double precision:** FSGNJX_D, a=64'hC000000000000000, b=64'h8000000000000000. Require o_result=64'h4000000000000000.
- **Unboxed operand:** FSGNJ_S, a=64'h00000000_3F800000, b=64'hFFFFFFFF_BF800000.
  - With macro defined: o_result=64'hFFFFFFFF_FFC00000.
  - With macro undefined: o_result=64'hFFFFFFFF_BF800000.
- **Backpressure:** issue tags 1, 2, 3 back-to-back with i_ready=0.
  - Require o_ready=0 after 2 accepts and tag 3 held at the input.
  - Raise i_ready: tags 1, 2, 3 emerge on consecutive cycles, in order, with o_result stable while stalled.
- **Reset and illegal op:** with 2 ops in flight, pull i_rst_n low for 1 cycle.
  - Require o_valid=0, o_busy=0, o_ready=1 and no late outputs.
  - Then i_valid with FADD_S: nothing accepted, no o_valid.
- **Back-to-back throughput:** STAGES=1, 8 ops streamed with i_ready=1. Require 8 consecutive o_valid cycles with correct results.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared FPU definitions: instruction opcodes, canonical NaN and helpers
// for the sign-injection family.
package riscv_pkg;

  typedef enum logic [4:0] {
    FADD_S,
    FSUB_S,
    FMUL_S,
    FDIV_S,
    FSGNJ_S,
    FSGNJN_S,
    FSGNJX_S,
    FMIN_S,
    FMAX_S,
    FADD_D,
    FSUB_D,
    FSGNJ_D,
    FSGNJN_D,
    FSGNJX_D
  } instr_op_e;

  localparam logic [31:0] FP_CANON_NAN_S = 32'h7FC0_0000;

  function automatic logic op_is_sgnj_s(instr_op_e op);
    return (op == FSGNJ_S) || (op == FSGNJN_S) || (op == FSGNJX_S);
  endfunction

  function automatic logic op_is_sgnj_d(instr_op_e op);
    return (op == FSGNJ_D) || (op == FSGNJN_D) || (op == FSGNJX_D);
  endfunction

  // Injected sign: copy, negate or xor the sign of fs2 into fs1.
  function automatic logic sgnj_sign(instr_op_e op, logic sa, logic sb);
    logic s;
    case (op)
      FSGNJ_S, FSGNJ_D:   s = sb;
      FSGNJN_S, FSGNJN_D: s = ~sb;
      default:            s = sa ^ sb;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/fp_pipe_stage.sv
// One elastic valid/ready register stage. Loads whenever it is empty or its
// content is leaving, so bubbles collapse without waiting for downstream.
module fp_pipe_stage #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign o_ready = !valid_q || i_ready;
  assign o_valid = valid_q;
  assign o_data  = data_q;

  // Next state: take upstream content when there is room, otherwise hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (o_ready) begin
      valid_d = i_valid;
      if (i_valid) data_d = i_data;
    end
  end

  // Stage register with synchronous active-low clear.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/fp_sign_inject_pipe.sv
// Pipelined FSGNJ/FSGNJN/FSGNJX unit for single and (FLEN=64) double
// precision with NaN-boxing. Result is formed at entry and then carried,
// with its tag, through STAGES elastic register stages.
// Optional build macro: FP_SGNJ_NANBOX_CHECK_EN -- when defined, improperly
// boxed single-precision operands are replaced by the canonical NaN.
module fp_sign_inject_pipe
  import riscv_pkg::*;
#(
  parameter int FLEN   = 64,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [FLEN-1:0]  i_operand_a,
  input  logic [FLEN-1:0]  i_operand_b,
  input  instr_op_e        i_operation,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [FLEN-1:0]  o_result,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_busy
);

  localparam int W = FLEN + TAG_W;

  if (FLEN != 32 && FLEN != 64) begin : g_bad_flen
    $error("fp_sign_inject_pipe: FLEN must be 32 or 64");
  end
  if (STAGES < 1) begin : g_bad_stages
    $error("fp_sign_inject_pipe: STAGES must be at least 1");
  end

  logic            op_single, op_double, op_ok;
  logic [FLEN-1:0] res;
  logic            unused_operands;

  // Some operand bits never reach the result in a given build.
  assign unused_operands = ^{i_operand_a, i_operand_b};

  // Decode: double-precision ops exist only in a 64-bit register file.
  always_comb begin
    op_single = op_is_sgnj_s(i_operation);
    op_double = (FLEN == 64) && op_is_sgnj_d(i_operation);
    op_ok     = op_single || op_double;
  end

  if (FLEN == 64) begin : g_flen64
    logic [31:0] a_s, b_s;

    // Unbox single-precision operands, then build the entry result.
    always_comb begin
`ifdef FP_SGNJ_NANBOX_CHECK_EN
      a_s = (&i_operand_a[63:32]) ? i_operand_a[31:0] : FP_CANON_NAN_S;
      b_s = (&i_operand_b[63:32]) ? i_operand_b[31:0] : FP_CANON_NAN_S;
`else
      a_s = i_operand_a[31:0];
      b_s = i_operand_b[31:0];
`endif
      if (op_double) begin
        res = {sgnj_sign(i_operation, i_operand_a[63], i_operand_b[63]),
               i_operand_a[62:0]};
      end else begin
        res = {32'hFFFF_FFFF, sgnj_sign(i_operation, a_s[31], b_s[31]), a_s[30:0]};
      end
    end
  end else begin : g_flen32
    // Single precision only, no boxing in a 32-bit register file.
    always_comb begin
      res = {sgnj_sign(i_operation, i_operand_a[FLEN-1], i_operand_b[FLEN-1]),
             i_operand_a[FLEN-2:0]};
    end
  end

  logic [STAGES:0] stg_valid;
  logic [STAGES:0] stg_ready;
  logic [W-1:0]    stg_data [0:STAGES];

  assign stg_valid[0]      = i_valid && op_ok;
  assign stg_data[0]       = {res, i_tag};
  assign stg_ready[STAGES] = i_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    fp_pipe_stage #(.W(W)) u_stage (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_valid (stg_valid[k]),
      .o_ready (stg_ready[k]),
      .i_data  (stg_data[k]),
      .o_valid (stg_valid[k+1]),
      .i_ready (stg_ready[k+1]),
      .o_data  (stg_data[k+1])
    );
  end

  // Ready is offered even for unsupported ops; they are simply not loaded.
  assign o_ready  = stg_ready[0];
  assign o_valid  = stg_valid[STAGES];
  assign o_result = stg_data[STAGES][W-1:TAG_W];
  assign o_tag    = stg_data[STAGES][TAG_W-1:0];
  assign o_busy   = |stg_valid[STAGES:1];

endmodule
